// File: rtl/multi_lap_timer_if.sv
// Port bundle between track/checkpoint logic (master) and the lap timer (slave).
// Per-channel fields are packed with channel k at [k*W +: W].
interface multi_lap_timer_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned TW   = 16,
  parameter int unsigned LW   = 4,
  parameter int unsigned IW   = 1
);
  logic                 start;
  logic                 stop;
  logic                 new_race;
  logic                 clear_best;
  logic [N_CH-1:0]      lap_finished;
  logic [N_CH-1:0]      checkpoints_passed;
  logic [N_CH*TW-1:0]   current_lap_time;
  logic [N_CH*TW-1:0]   last_lap_time;
  logic [N_CH*TW-1:0]   best_lap_time;
  logic [N_CH*LW-1:0]   lap_count;
  logic [N_CH-1:0]      max_time_exceeded;
  logic [N_CH-1:0]      race_done;
  logic                 winner_valid;
  logic [IW-1:0]        winner_id;

  modport master (
    output start, stop, new_race, clear_best, lap_finished, checkpoints_passed,
    input  current_lap_time, last_lap_time, best_lap_time, lap_count,
    input  max_time_exceeded, race_done, winner_valid, winner_id
  );

  modport slave (
    input  start, stop, new_race, clear_best, lap_finished, checkpoints_passed,
    output current_lap_time, last_lap_time, best_lap_time, lap_count,
    output max_time_exceeded, race_done, winner_valid, winner_id
  );
endinterface

// File: rtl/multi_lap_timer.sv
// N-channel lap timer: shared 0.01 s prescaler, per-channel lap FSM with
// current/last/best times, valid-lap counting, overflow detection and winner selection.
module multi_lap_timer #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned TW           = 16,
  parameter int unsigned CLK_DIV      = 650000,
  parameter int unsigned MAX_LAP_TIME = 4000,
  parameter int unsigned MIN_LAP_TIME = 100,
  parameter int unsigned RACE_LAPS    = 3,
  parameter int unsigned LW           = 4,
  parameter int unsigned IW           = 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  multi_lap_timer_if.slave  bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StCount, StLapDone, StFinished} state_e;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [TW-1:0]   cur_q   [N_CH];
  logic [TW-1:0]   cur_d   [N_CH];
  logic [TW-1:0]   last_q  [N_CH];
  logic [TW-1:0]   last_d  [N_CH];
  logic [TW-1:0]   best_q  [N_CH];
  logic [TW-1:0]   best_d  [N_CH];
  logic [LW-1:0]   cnt_q   [N_CH];
  logic [LW-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] valid;

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick, any_count, any_start;
  logic            win_valid_q, win_valid_d;
  logic [IW-1:0]   win_id_q, win_id_d;

  // Prescaler runs only while some channel is timing; a resume restarts its phase.
  always_comb begin
    any_count = 1'b0;
    any_start = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      any_count = any_count | (state_q[k] == StCount);
      any_start = any_start | ((state_q[k] == StIdle) && bus.start && !bus.stop);
    end
    tick    = any_count && (presc_q == PW'(CLK_DIV - 1));
    presc_d = presc_q;
    if (bus.new_race || any_start) begin
      presc_d = '0;
    end else if (any_count) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      cur_d[k]   = cur_q[k];
      last_d[k]  = last_q[k];
      cnt_d[k]   = cnt_q[k];
      best_d[k]  = bus.clear_best ? '0 : best_q[k];
      valid[k]   = (cur_q[k] > TW'(MIN_LAP_TIME)) && !ovf_q[k] && bus.checkpoints_passed[k];

      if (bus.new_race) begin
        state_d[k] = StIdle;
        cur_d[k]   = '0;
        last_d[k]  = '0;
        cnt_d[k]   = '0;
        ovf_d[k]   = 1'b0;
      end else begin
        unique case (state_q[k])
          StIdle: begin
            if (!bus.stop && bus.start) state_d[k] = StCount;
          end
          StCount: begin
            if (tick) begin
              if (cur_q[k] < TW'(MAX_LAP_TIME)) begin
                cur_d[k] = cur_q[k] + TW'(1);
              end else begin
                cur_d[k] = '0;
                ovf_d[k] = 1'b1;
              end
            end
            if (bus.stop)                 state_d[k] = StIdle;
            else if (bus.lap_finished[k]) state_d[k] = StLapDone;
          end
          StLapDone: begin
            cur_d[k] = '0;
            ovf_d[k] = 1'b0;
            if (valid[k]) begin
              last_d[k] = cur_q[k];
              cnt_d[k]  = cnt_q[k] + LW'(1);
              // A lap landing on the same cycle as clear_best becomes the new best.
              if (bus.clear_best || (best_q[k] == '0) || (cur_q[k] < best_q[k])) begin
                best_d[k] = cur_q[k];
              end
            end
            if (valid[k] && (cnt_q[k] + LW'(1) == LW'(RACE_LAPS))) state_d[k] = StFinished;
            else if (bus.stop)                                     state_d[k] = StIdle;
            else                                                   state_d[k] = StCount;
          end
          StFinished: begin
          end
          default: state_d[k] = StIdle;
        endcase
      end
    end
  end

  // Descending scan so the lowest-index simultaneous finisher wins.
  always_comb begin
    win_valid_d = win_valid_q;
    win_id_d    = win_id_q;
    if (bus.new_race) begin
      win_valid_d = 1'b0;
      win_id_d    = '0;
    end else if (!win_valid_q) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if ((state_d[k] == StFinished) && (state_q[k] != StFinished)) begin
          win_valid_d = 1'b1;
          win_id_d    = IW'(k);
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      win_valid_q <= 1'b0;
      win_id_q    <= '0;
      ovf_q       <= '0;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= StIdle;
        cur_q[k]   <= '0;
        last_q[k]  <= '0;
        best_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      ovf_q       <= ovf_d;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        cur_q[k]   <= cur_d[k];
        last_q[k]  <= last_d[k];
        best_q[k]  <= best_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign bus.current_lap_time[g*TW +: TW] = cur_q[g];
    assign bus.last_lap_time[g*TW +: TW]    = last_q[g];
    assign bus.best_lap_time[g*TW +: TW]    = best_q[g];
    assign bus.lap_count[g*LW +: LW]        = cnt_q[g];
    assign bus.race_done[g]                 = (state_q[g] == StFinished);
  end

  assign bus.max_time_exceeded = ovf_q;
  assign bus.winner_valid      = win_valid_q;
  assign bus.winner_id         = win_id_q;

endmodule

// File: tb/tb_multi_lap_timer.sv
// Directed bench for multi_lap_timer with N_CH=2, CLK_DIV=4, MIN=5, MAX=20, RACE_LAPS=2.
module tb_multi_lap_timer;

  logic pclk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 pclk = ~pclk;

  multi_lap_timer_if #(.N_CH(2), .TW(16), .LW(4), .IW(1)) bus ();

  multi_lap_timer #(
    .N_CH(2), .TW(16), .CLK_DIV(4), .MAX_LAP_TIME(20), .MIN_LAP_TIME(5),
    .RACE_LAPS(2), .LW(4), .IW(1)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] cur(input int ch);
    return bus.current_lap_time[ch*16 +: 16];
  endfunction
  function automatic logic [15:0] last(input int ch);
    return bus.last_lap_time[ch*16 +: 16];
  endfunction
  function automatic logic [15:0] best(input int ch);
    return bus.best_lap_time[ch*16 +: 16];
  endfunction
  function automatic logic [3:0] cnt(input int ch);
    return bus.lap_count[ch*4 +: 4];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.start = 1'b1;
    else            bus.new_race = 1'b1;
    step(1);
    bus.start    = 1'b0;
    bus.new_race = 1'b0;
  endtask

  // Lap pulse, then the LAP_DONE cycle; returns with the lap resolved.
  task automatic pulse_lap(input logic [1:0] m);
    bus.lap_finished = m;
    step(1);
    bus.lap_finished = 2'b00;
    step(1);
  endtask

  task automatic wait_cur(input int ch, input logic [15:0] val, input int budget);
    int i = 0;
    while (cur(ch) !== val && i < budget) begin
      step(1);
      i++;
    end
    if (cur(ch) !== val) begin
      n_total++;
      $display("FAIL wait_cur ch%0d: got %0d want %0d within %0d cycles", ch, cur(ch), val, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.new_race = 1'b0; bus.clear_best = 1'b0;
    bus.lap_finished = 2'b00; bus.checkpoints_passed = 2'b00;
    step(2);
    n_total++;
    if ({bus.current_lap_time, bus.last_lap_time, bus.best_lap_time} !== 96'h0)
      $display("FAIL reset_times: got %h want 0",
               {bus.current_lap_time, bus.last_lap_time, bus.best_lap_time});
    else n_pass++;
    n_total++;
    if ({bus.lap_count, bus.max_time_exceeded, bus.race_done, bus.winner_valid, bus.winner_id}
        !== 14'h0)
      $display("FAIL reset_flags: got %h want 0",
               {bus.lap_count, bus.max_time_exceeded, bus.race_done, bus.winner_valid,
                bus.winner_id});
    else n_pass++;
    rst_n = 1'b1;
    step(10);
    n_total++;
    if ({cur(0), cur(1)} !== 32'h0)
      $display("FAIL idle_no_count: got %h want 0", {cur(0), cur(1)});
    else n_pass++;
  endtask

  task automatic test_count;
    pulse(0);
    step(40);
    n_total++;
    if ({cur(0), cur(1)} !== {16'd10, 16'd10})
      $display("FAIL count_40: got %0d/%0d want 10/10", cur(0), cur(1));
    else n_pass++;
    step(3);
    n_total++;
    if (cur(0) !== 16'd10) $display("FAIL tick_hold: got %0d want 10", cur(0));
    else n_pass++;
    step(1);
    n_total++;
    if (cur(0) !== 16'd11) $display("FAIL tick_period: got %0d want 11", cur(0));
    else n_pass++;
  endtask

  task automatic test_valid_laps;
    pulse(1);
    n_total++;
    if ({cur(0), cur(1), cnt(0), cnt(1)} !== 40'h0)
      $display("FAIL new_race_clear: got %h want 0", {cur(0), cur(1), cnt(0), cnt(1)});
    else n_pass++;
    bus.checkpoints_passed = 2'b11;
    pulse(0);
    wait_cur(0, 16'd8, 100);
    pulse_lap(2'b01);
    n_total++;
    if ({last(0), best(0), cnt(0), cur(0)} !== {16'd8, 16'd8, 4'd1, 16'd0})
      $display("FAIL lap1_ch0: got %h want 0008_0008_1_0000", {last(0), best(0), cnt(0), cur(0)});
    else n_pass++;
    n_total++;
    if ({bus.race_done, bus.winner_valid} !== 3'b000)
      $display("FAIL lap1_no_winner: got %b want 000", {bus.race_done, bus.winner_valid});
    else n_pass++;
    wait_cur(0, 16'd6, 100);
    pulse_lap(2'b01);
    n_total++;
    if ({last(0), best(0), cnt(0)} !== {16'd6, 16'd6, 4'd2})
      $display("FAIL lap2_ch0: got %h want 0006_0006_2", {last(0), best(0), cnt(0)});
    else n_pass++;
    n_total++;
    if ({bus.race_done, bus.winner_valid, bus.winner_id} !== 4'b0110)
      $display("FAIL winner_ch0: got %b want 0110",
               {bus.race_done, bus.winner_valid, bus.winner_id});
    else n_pass++;
  endtask

  task automatic test_invalid_laps;
    bus.checkpoints_passed = 2'b01;
    pulse_lap(2'b11);
    n_total++;
    if ({last(1), best(1), cnt(1), cur(1)} !== 52'h0)
      $display("FAIL no_checkpoint: got %h want 0", {last(1), best(1), cnt(1), cur(1)});
    else n_pass++;
    bus.checkpoints_passed = 2'b11;
    wait_cur(1, 16'd4, 100);
    pulse_lap(2'b10);
    n_total++;
    if ({last(1), best(1), cnt(1), cur(1)} !== 52'h0)
      $display("FAIL short_lap_4: got %h want 0", {last(1), best(1), cnt(1), cur(1)});
    else n_pass++;
    wait_cur(1, 16'd5, 100);
    pulse_lap(2'b10);
    n_total++;
    if ({last(1), best(1), cnt(1), cur(1)} !== 52'h0)
      $display("FAIL min_boundary_5: got %h want 0", {last(1), best(1), cnt(1), cur(1)});
    else n_pass++;
  endtask

  task automatic test_overflow;
    wait_cur(1, 16'd20, 200);
    n_total++;
    if (bus.max_time_exceeded !== 2'b00)
      $display("FAIL at_max_no_flag: got %b want 00", bus.max_time_exceeded);
    else n_pass++;
    wait_cur(1, 16'd0, 20);
    n_total++;
    if ({bus.max_time_exceeded, cur(1)} !== {2'b10, 16'd0})
      $display("FAIL overflow_wrap: got %b/%0d want 10/0", bus.max_time_exceeded, cur(1));
    else n_pass++;
    wait_cur(1, 16'd7, 100);
    pulse_lap(2'b11);
    n_total++;
    if ({bus.max_time_exceeded, last(1), cnt(1), cur(1)} !== 38'h0)
      $display("FAIL overflow_reject: got %h want 0",
               {bus.max_time_exceeded, last(1), cnt(1), cur(1)});
    else n_pass++;
    n_total++;
    if ({last(0), best(0), cnt(0), cur(0), bus.race_done, bus.winner_valid, bus.winner_id}
        !== {16'd6, 16'd6, 4'd2, 16'd0, 2'b01, 1'b1, 1'b0})
      $display("FAIL ch0_frozen: got %h/%0d/%0d/%0d/%b", last(0), best(0), cnt(0), cur(0),
               bus.race_done);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    pulse(1);
    n_total++;
    if ({cnt(0), cnt(1), bus.winner_valid, bus.race_done, best(0), best(1)}
        !== {4'd0, 4'd0, 1'b0, 2'b00, 16'd6, 16'd0})
      $display("FAIL new_race_keep_best: got %h want 00_0_0_0006_0000",
               {cnt(0), cnt(1), bus.winner_valid, bus.race_done, best(0), best(1)});
    else n_pass++;
    pulse(0);
    wait_cur(0, 16'd7, 100);
    pulse_lap(2'b11);
    wait_cur(0, 16'd7, 100);
    pulse_lap(2'b11);
    n_total++;
    if ({bus.race_done, bus.winner_valid, bus.winner_id} !== 4'b1110)
      $display("FAIL tie_winner: got %b want 1110", {bus.race_done, bus.winner_valid,
                                                     bus.winner_id});
    else n_pass++;
    n_total++;
    if ({cnt(0), cnt(1), best(0), best(1), last(1)} !== {4'd2, 4'd2, 16'd6, 16'd7, 16'd7})
      $display("FAIL tie_regs: got %h want 2_2_0006_0007_0007",
               {cnt(0), cnt(1), best(0), best(1), last(1)});
    else n_pass++;
  endtask

  task automatic test_stop_with_lap;
    pulse(1);
    pulse(0);
    wait_cur(0, 16'd7, 100);
    bus.stop = 1'b1;
    bus.lap_finished = 2'b01;
    step(1);
    bus.stop = 1'b0;
    bus.lap_finished = 2'b00;
    step(8);
    n_total++;
    if ({cnt(0), last(0), cur(0), cur(1)} !== {4'd0, 16'd0, 16'd7, 16'd7})
      $display("FAIL stop_over_lap: got %h want 0_0000_0007_0007",
               {cnt(0), last(0), cur(0), cur(1)});
    else n_pass++;
    pulse(0);
    step(3);
    n_total++;
    if (cur(0) !== 16'd7) $display("FAIL resume_hold: got %0d want 7", cur(0));
    else n_pass++;
    step(1);
    n_total++;
    if (cur(0) !== 16'd8) $display("FAIL resume_tick: got %0d want 8", cur(0));
    else n_pass++;
  endtask

  task automatic test_clear_best;
    wait_cur(0, 16'd9, 100);
    bus.lap_finished = 2'b01;
    step(1);
    bus.lap_finished = 2'b00;
    bus.clear_best = 1'b1;
    step(1);
    bus.clear_best = 1'b0;
    n_total++;
    if ({best(0), best(1), last(0), cnt(0)} !== {16'd9, 16'd0, 16'd9, 4'd1})
      $display("FAIL clear_best_lap_wins: got %h want 0009_0000_0009_1",
               {best(0), best(1), last(0), cnt(0)});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    step(5);
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({bus.current_lap_time, bus.last_lap_time, bus.best_lap_time, bus.lap_count,
         bus.max_time_exceeded, bus.race_done, bus.winner_valid, bus.winner_id} !== 110'h0)
      $display("FAIL async_reset: got %h want 0",
               {bus.current_lap_time, bus.last_lap_time, bus.best_lap_time, bus.lap_count});
    else n_pass++;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count();
    test_valid_laps();
    test_invalid_laps();
    test_overflow();
    test_simultaneous();
    test_stop_with_lap();
    test_clear_best();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_lap_timer.md
Name: multi_lap_timer

Overview:
- Parametrised N-channel lap timer for multi-player racing.
- Each channel times its own lap in 0.01 s units and keeps current, last and best lap times.
- Each channel also counts valid laps and detects lap-time overflow.
- A shared prescaler generates the time base; a race controller declares a winner when a channel completes RACE_LAPS valid laps.
- Sits between the track/checkpoint logic and the HUD/scoreboard.

Parameters:
- N_CH, 2, number of player channels (1..8).
- TW, 16, lap-time width in ticks.
- CLK_DIV, 650000, pclk cycles per 0.01 s tick.
- MAX_LAP_TIME, 4000, tick count at which a lap is declared overflowed.
- MIN_LAP_TIME, 100, a lap must strictly exceed this to be valid.
- RACE_LAPS, 3, valid laps needed to finish (1..15).
- LW, 4, lap-counter width.
- IW, 1, winner index width (≥ clog2(N_CH), min 1).

Ports:
- pclk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  global start/resume
- stop  in  1  global pause
- new_race  in  1  clears race state; best times kept
- clear_best  in  1  clears all best_lap_time
- lap_finished  in  N_CH  per-channel finish-line pulse
- checkpoints_passed  in  N_CH  per-channel checkpoint-complete level
- current_lap_time  out  N_CH*TW  channel k at [k*TW +: TW]
- last_lap_time  out  N_CH*TW  last valid lap time
- best_lap_time  out  N_CH*TW  best valid lap time; 0 = none yet
- lap_count  out  N_CH*LW  valid laps completed
- max_time_exceeded  out  N_CH  sticky per-lap overflow flag
- race_done  out  N_CH  channel has finished the race
- winner_valid  out  1  a winner has been declared
- winner_id  out  IW  index of the winning channel

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock port is pclk, reset port is rst_n.
- Reset values: all outputs 0; prescaler 0; every channel in IDLE.
- Prescaler:
  - Counts 0..CLK_DIV-1 while any channel is in COUNT; holds otherwise.
  - tick is asserted for exactly one cycle at terminal count, then the count wraps to 0.
  - Cleared to 0 on the cycle start is accepted from IDLE.
- Per-channel FSM states: IDLE, COUNT, LAP_DONE, FINISHED.
- Transition priority each cycle: new_race > stop > lap_finished > start.
- IDLE:
  - All channel registers hold.
  - start moves to COUNT; current_lap_time is preserved (resume).
- COUNT:
  - On tick: if current < MAX_LAP_TIME, current += 1.
  - Otherwise current <= 0 and max_time_exceeded <= 1.
  - stop moves to IDLE.
  - lap_finished moves to LAP_DONE next cycle.
- LAP_DONE (exactly 1 cycle; any tick in this cycle is dropped for the channel):
  - valid = (current > MIN_LAP_TIME) && !max_time_exceeded && checkpoints_passed[k].
  - If valid:
    - last <= current.
    - best <= current if best == 0 or current < best.
    - lap_count += 1.
  - Always: current <= 0 and max_time_exceeded <= 0.
  - If valid and the new lap_count == RACE_LAPS, go to FINISHED.
  - Else if stop, go to IDLE.
  - Else go to COUNT.
- FINISHED:
  - Registers frozen; race_done[k] = 1.
  - start, stop and lap_finished are ignored.
  - Leaves only on new_race or reset.
- new_race (any state):
  - Next cycle all channels are in IDLE.
  - current, last, lap_count, max_time_exceeded, race_done, winner_valid and winner_id are all 0.
  - best is retained; prescaler <= 0.
- clear_best:
  - Zeroes every best_lap_time.
  - If it coincides with a LAP_DONE valid update, the new lap is written as best (lap wins).
- Winner:
  - On the first cycle any channel enters FINISHED while winner_valid == 0, set winner_valid = 1 and winner_id to that channel.
  - Simultaneous finishers: the lowest index wins.
  - Sticky until new_race or reset.
- Width rules:
  - All comparisons are unsigned.
  - lap_count never exceeds RACE_LAPS.
  - MAX_LAP_TIME must be < 2^TW.
- Reset mid-lap: asynchronous clear to reset values regardless of state; prescaler phase lost.

Test Plan (N_CH=2, CLK_DIV=4, MIN_LAP_TIME=5, MAX_LAP_TIME=20, RACE_LAPS=2):
- Release rst_n, pulse start, hold 40 cycles -> both current_lap_time = 10; tick period 4 cycles.
- Ch0: lap_finished at current=8 with checkpoints_passed=1 -> last=8, best=8, lap_count=1, current=0.
- Ch0: next lap finished at 6 -> best=6, race_done[0]=1, winner_valid=1, winner_id=0.
- Ch1: lap at current=4, then a lap with checkpoints_passed=0 -> both invalid; last=0, best=0, lap_count=0.
- Ch1: run past 20 ticks -> current wraps to 0, max_time_exceeded[1]=1; the next lap_finished is rejected and the flag clears.
- Both channels finish on the same cycle -> winner_id=0. Then stop asserted together with lap_finished -> channel goes to IDLE, no update. Then new_race -> lap_count=0 and winner_valid=0, best retained. Then assert rst_n=0 mid-count -> all outputs 0 immediately.
